// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, sync polarity and colour type shared with the pixel generator.
package vga_pkg;
  localparam int H_ACTIVE     = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_ACTIVE     = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
  localparam logic SYNC_POL   = 1'b0;
  typedef logic [11:0] rgb_t;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis; advances when en_i and wrap_i coincide, flags active/sync/wrap.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 751,
  parameter int ACTIVE     = 640,
  parameter int W          = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         wrap_i,
  output logic [W-1:0] count_o,
  output logic         active_o,
  output logic         sync_o,
  output logic         wrap_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         last;
  assign last  = cnt_q == W'(TOTAL - 1);
  assign cnt_d = last ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (en_i && wrap_i) cnt_q <= cnt_d;
  end
  assign count_o  = cnt_q;
  assign active_o = cnt_q < W'(ACTIVE);
  assign sync_o   = (cnt_q >= W'(SYNC_START) && cnt_q <= W'(SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  // wrap_o is the carry into the next axis; it excludes en_i so the caller gates it with ce.
  assign wrap_o   = wrap_i && last;
endmodule

// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl: 640x480@60 timing generator with pixel-rate divider and aligned colour/sync pipeline.
module vga_sync_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int PIPE_DLY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_valid,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] vga_rgb,
  output logic        frame_start
);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div_q, div_d;
  logic          ce;
  logic [9:0]    h_cnt, v_cnt;
  logic          h_act, v_act, hs_raw, vs_raw, h_wrap, f_wrap;
  rgb_t [PIPE_DLY-1:0] rgb_q;
  logic [PIPE_DLY-1:0] hs_q, vs_q;
  assign ce    = div_q == DW'(CLK_DIV - 1);
  assign div_d = ce ? '0 : div_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else div_q <= div_d;
  end
  vga_axis_counter #(
    .TOTAL(H_TOTAL), .SYNC_START(H_SYNC_START), .SYNC_END(H_SYNC_END), .ACTIVE(H_ACTIVE), .W(10)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .en_i(ce), .wrap_i(1'b1),
    .count_o(h_cnt), .active_o(h_act), .sync_o(hs_raw), .wrap_o(h_wrap)
  );
  vga_axis_counter #(
    .TOTAL(V_TOTAL), .SYNC_START(V_SYNC_START), .SYNC_END(V_SYNC_END), .ACTIVE(V_ACTIVE), .W(10)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .en_i(ce), .wrap_i(h_wrap),
    .count_o(v_cnt), .active_o(v_act), .sync_o(vs_raw), .wrap_o(f_wrap)
  );
  assign pix_valid   = h_act && v_act;
  assign pix_x       = pix_valid ? h_cnt : '0;
  assign pix_y       = pix_valid ? 9'(v_cnt) : '0;
  assign frame_start = ce && f_wrap;
  // Stage 0 samples the coordinates held before the counters advance, so colour and sync stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      hs_q  <= {PIPE_DLY{~SYNC_POL}};
      vs_q  <= {PIPE_DLY{~SYNC_POL}};
    end else if (ce) begin
      rgb_q[0] <= pix_valid ? rgb_in : '0;
      hs_q[0]  <= hs_raw;
      vs_q[0]  <= vs_raw;
      for (int i = 1; i < PIPE_DLY; i++) begin
        rgb_q[i] <= rgb_q[i-1];
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
      end
    end
  end
  assign vga_rgb = rgb_q[PIPE_DLY-1];
  assign hsync   = hs_q[PIPE_DLY-1];
  assign vsync   = vs_q[PIPE_DLY-1];
endmodule
